function_sequencer: RTL
=======================

// Module: function_sequencer
// PURPOSE
//  Parametrised successor of the fixed 4-entry function generator. Holds a writable table of
//  NUM_FUNC seed words (K_N bits) and, on start, streams each seed plus its ROT_STEPS-1
//  cyclic right rotations (circulant rows) to the parallel encoder datapath.
//  Output uses a valid/ready handshake. The table is reloaded at run time instead of being hard-coded.
// PARAMETERS
//  K_N        256  width of one function word / circulant row
//  NUM_FUNC   4    table depth (>=2); ADRS_W = $clog2(NUM_FUNC)
//  ROT_STEPS  16   rows emitted per function (Lm), >=1
//  ROT_SHIFT  1    right-rotation distance between consecutive rows, 0 < ROT_SHIFT < K_N
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  clr         in   1        synchronous abort/clear
//  wr_en       in   1        table write strobe
//  wr_adrs     in   ADRS_W   table write address
//  wr_data     in   K_N      table write data
//  start       in   1        begin sequence (sampled in IDLE only)
//  start_adrs  in   ADRS_W   first table entry of the sequence
//  f           out  K_N      current row
//  f_valid     out  1        f valid
//  f_ready     in   1        consumer accepts f when f_valid&f_ready
//  f_adrs      out  ADRS_W   table entry that f derives from
//  f_row       out  $clog2(ROT_STEPS)+1  row index 0..ROT_STEPS-1
//  f_last      out  1        final row of the final function
//  busy        out  1        state != IDLE
//  done        out  1        one-cycle pulse after the final row is accepted
// BEHAVIOUR
//  Reset (rst_n=0): state IDLE; f=0, f_valid=0, f_adrs=0, f_row=0, f_last=0, busy=0, done=0.
//   Every table entry resets to 0.
//  Table: wr_en writes wr_data to entry wr_adrs at the clock edge. Writes are legal in any state.
//   A LOAD in the same cycle as a write to that entry reads the old value.
//   wr_adrs >= NUM_FUNC: the write is dropped.
//  FSM: IDLE -> LOAD -> EMIT -> (LOAD | DONE) -> IDLE.
//   IDLE: start=1 latches cur_adrs=start_adrs and func_cnt=0, then goes to LOAD.
//    start_adrs >= NUM_FUNC is treated as 0.
//   LOAD (1 cycle): work_reg <= table[cur_adrs]; row=0; go to EMIT.
//   EMIT: f=work_reg, f_valid=1, f_adrs=cur_adrs, f_row=row. f and the sideband hold stable until accepted.
//    On accept with row<ROT_STEPS-1: work_reg <= rotr(work_reg,ROT_SHIFT), row++.
//     The next row is valid on the next cycle, so back-to-back accepts give one row per clock.
//    On accept with row=ROT_STEPS-1 and func_cnt<NUM_FUNC-1: cur_adrs wraps to 0 after NUM_FUNC-1,
//     func_cnt++, go to LOAD. This produces a 1-cycle f_valid=0 bubble.
//    On accept with row=ROT_STEPS-1 and func_cnt=NUM_FUNC-1: go to DONE.
//   DONE (1 cycle): done=1, f_valid=0; go to IDLE.
//  rotr(x,s) = (x >> s) | (x << (K_N-s)), truncated to K_N bits.
//  f_last = f_valid & (row==ROT_STEPS-1) & (func_cnt==NUM_FUNC-1).
//  f is registered. In IDLE/LOAD/DONE, f holds its last value and f_valid=0.
//  Latency: start sampled at edge t -> LOAD in cycle t+1 -> first f_valid=1 in cycle t+2.
//  One full run emits NUM_FUNC*ROT_STEPS rows in total.
//  start while busy is ignored. f_ready while f_valid=0 is ignored.
//  clr=1 (any state, priority over start/accept): next state IDLE; f=0, f_valid=0, done=0.
//   The table is retained and writes in the same cycle still take effect.
//  rst_n asserted mid-run: immediate abort to the reset values, including clearing the table.
// TESTING
//  1 Write table[0]=256'h1, start_adrs=0, f_ready=1 -> row0 f=256'h1; row1 f=256'h8000...0 (bit255);
//    row15 f has only bit 241 set; first f_valid at start+2.
//  2 Load 4 distinct seeds, start_adrs=2, f_ready=1 -> f_adrs sequence 2,3,0,1 with 16 rows each;
//    one bubble between functions; f_last only on row15 of adrs1; done one cycle after that.
//  3 Random f_ready backpressure -> f and f_adrs/f_row stable while f_valid&!f_ready;
//    no row lost or duplicated (compare against a model of 64 rows).
//  4 start held high through the run, and pulsed while busy -> exactly one run; busy=1 throughout.
//  5 clr asserted at row 7 of function 1 -> next cycle IDLE, f=0, f_valid=0, no done.
//    A new start then replays from row 0 with the table intact.
//  6 rst_n pulsed low mid-EMIT -> all outputs and table zero asynchronously.
//    A write to entry 0 in the same cycle as LOAD of entry 0 -> the old value is emitted.

Source files
------------

// File: rtl/function_sequencer_if.sv
// Row stream from the function sequencer to the parallel encoder datapath.
// The master drives a circulant row plus its sideband; the slave returns f_ready.
interface function_sequencer_if #(
    parameter int K_N       = 256,
    parameter int NUM_FUNC  = 4,
    parameter int ROT_STEPS = 16
);
    localparam int ADRS_W = $clog2(NUM_FUNC);
    localparam int ROW_W  = $clog2(ROT_STEPS) + 1;

    logic [K_N-1:0]    f;
    logic              f_valid;
    logic              f_ready;
    logic [ADRS_W-1:0] f_adrs;
    logic [ROW_W-1:0]  f_row;
    logic              f_last;

    modport master (
        output f, f_valid, f_adrs, f_row, f_last,
        input  f_ready
    );

    modport slave (
        input  f, f_valid, f_adrs, f_row, f_last,
        output f_ready
    );
endinterface

// File: rtl/function_sequencer.sv
// Function sequencer: a run-time writable table of NUM_FUNC seed words. On start it
// walks the table from start_adrs (wrapping), and for each seed streams the seed and
// its ROT_STEPS-1 successive right rotations as circulant rows over a valid/ready link.
module function_sequencer #(
    parameter int  K_N       = 256,
    parameter int  NUM_FUNC  = 4,
    parameter int  ROT_STEPS = 16,
    parameter int  ROT_SHIFT = 1,
    localparam int ADRS_W    = $clog2(NUM_FUNC),
    localparam int ROW_W     = $clog2(ROT_STEPS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADRS_W-1:0] wr_adrs,
    input  logic [K_N-1:0]    wr_data,
    input  logic              start,
    input  logic [ADRS_W-1:0] start_adrs,
    function_sequencer_if.master out_if,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADRS_W-1:0] cur_adrs_q, cur_adrs_d;
    logic [ADRS_W-1:0] func_cnt_q, func_cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [K_N-1:0]    work_q, work_d;
    logic [K_N-1:0]    table_q [NUM_FUNC];
    logic [K_N-1:0]    table_d [NUM_FUNC];

    logic row_end;
    logic func_end;
    logic adrs_end;

    // Right rotation by ROT_SHIFT, kept at K_N bits.
    function automatic logic [K_N-1:0] rotr(input logic [K_N-1:0] x);
        return (x >> ROT_SHIFT) | (x << (K_N - ROT_SHIFT));
    endfunction

    assign row_end  = (row_q == ROW_W'(ROT_STEPS - 1));
    assign func_end = (func_cnt_q == ADRS_W'(NUM_FUNC - 1));
    assign adrs_end = (cur_adrs_q == ADRS_W'(NUM_FUNC - 1));

    // Table update: out-of-range addresses are dropped; clr does not touch the table.
    always_comb begin
        table_d = table_q;
        if (wr_en && (32'(wr_adrs) < NUM_FUNC)) begin
            table_d[wr_adrs] = wr_data;
        end
    end

    // Sequencer next-state: clr overrides everything, LOAD reads the pre-write table.
    always_comb begin
        state_d    = state_q;
        cur_adrs_d = cur_adrs_q;
        func_cnt_d = func_cnt_q;
        row_d      = row_q;
        work_d     = work_q;
        if (clr) begin
            state_d    = IDLE;
            cur_adrs_d = '0;
            func_cnt_d = '0;
            row_d      = '0;
            work_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_adrs_d = (32'(start_adrs) < NUM_FUNC) ? start_adrs : '0;
                        func_cnt_d = '0;
                        state_d    = LOAD;
                    end
                end
                LOAD: begin
                    work_d  = table_q[cur_adrs_q];
                    row_d   = '0;
                    state_d = EMIT;
                end
                EMIT: begin
                    if (out_if.f_ready) begin
                        if (!row_end) begin
                            work_d = rotr(work_q);
                            row_d  = row_q + ROW_W'(1);
                        end else if (!func_end) begin
                            cur_adrs_d = adrs_end ? '0 : cur_adrs_q + ADRS_W'(1);
                            func_cnt_d = func_cnt_q + ADRS_W'(1);
                            state_d    = LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, row register and table, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_adrs_q <= '0;
            func_cnt_q <= '0;
            row_q      <= '0;
            work_q     <= '0;
            for (int i = 0; i < NUM_FUNC; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_adrs_q <= cur_adrs_d;
            func_cnt_q <= func_cnt_d;
            row_q      <= row_d;
            work_q     <= work_d;
            for (int i = 0; i < NUM_FUNC; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // The working register is the row output; it only changes on load, accept or clear.
    assign out_if.f       = work_q;
    assign out_if.f_valid = (state_q == EMIT);
    assign out_if.f_adrs  = cur_adrs_q;
    assign out_if.f_row   = row_q;
    assign out_if.f_last  = (state_q == EMIT) && row_end && func_end;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);

endmodule
